// File: rtl/ctrl_dec_pipe_if.sv
// ID-to-EX control bundle between the decode stage and ctrl_dec_pipe.
// master: drives ID fields, flush and ex_ready; observes id_ready and EX controls.
// slave : ctrl_dec_pipe side.
interface ctrl_dec_pipe_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic                  id_ready;
  logic                  is_rtype;
  logic                  is_itype;
  logic                  is_load;
  logic                  is_store;
  logic                  is_branch;
  logic                  is_jal;
  logic                  is_jalr;
  logic                  is_lui;
  logic                  is_auipc;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic                  flush;
  logic                  ex_ready;
  logic                  ex_valid;
  logic                  ex_reg_write;
  logic                  ex_is_load;
  logic                  ex_is_store;
  logic                  ex_is_branch;
  logic                  ex_is_jal;
  logic                  ex_is_jalr;
  logic                  ex_opa_sel;
  logic                  ex_opb_sel;
  logic                  ex_is_mdu;
  logic                  ex_illegal;
  logic [1:0]            ex_mem_to_reg;
  logic [4:0]            ex_alu_op;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mdu_busy;

  modport master (
    output id_valid, is_rtype, is_itype, is_load, is_store, is_branch, is_jal,
           is_jalr, is_lui, is_auipc, funct3, funct7, rs1, rs2, rd, flush, ex_ready,
    input  id_ready, ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_is_branch,
           ex_is_jal, ex_is_jalr, ex_opa_sel, ex_opb_sel, ex_is_mdu, ex_illegal,
           ex_mem_to_reg, ex_alu_op, ex_rd, mdu_busy
  );

  modport slave (
    input  id_valid, is_rtype, is_itype, is_load, is_store, is_branch, is_jal,
           is_jalr, is_lui, is_auipc, funct3, funct7, rs1, rs2, rd, flush, ex_ready,
    output id_ready, ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_is_branch,
           ex_is_jal, ex_is_jalr, ex_opa_sel, ex_opb_sel, ex_is_mdu, ex_illegal,
           ex_mem_to_reg, ex_alu_op, ex_rd, mdu_busy
  );
endinterface

// File: rtl/ctrl_dec_pipe.sv
// Registered RV32 control decoder: ID class flags/function fields -> ID/EX
// control bundle, with load-use bubble, divider structural hazard and flush.
// Ports: clk, rst (sync, active-high), bus (ctrl_dec_pipe_if.slave).
// REG_ADDR_W must match the connected interface instance.
module ctrl_dec_pipe #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input logic         clk,
  input logic         rst,
  ctrl_dec_pipe_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

  logic                  m_enc;
  logic                  is_mdu_c;
  logic                  illegal_c;
  logic                  reg_write_c;
  logic [1:0]            mem_to_reg_c;
  logic                  opa_sel_c;
  logic                  opb_sel_c;
  logic [4:0]            alu_op_c;
  logic                  use_rs1;
  logic                  use_rs2;
  logic                  load_use;
  logic                  div_op;
  logic                  div_block;
  logic                  hold;
  logic                  id_ready_c;
  logic                  accept;

  logic                  valid_q;
  logic                  reg_write_q;
  logic                  is_load_q;
  logic                  is_store_q;
  logic                  is_branch_q;
  logic                  is_jal_q;
  logic                  is_jalr_q;
  logic                  opa_sel_q;
  logic                  opb_sel_q;
  logic                  is_mdu_q;
  logic                  illegal_q;
  logic [1:0]            mem_to_reg_q;
  logic [4:0]            alu_op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]      div_cnt;

  // Instruction decode
  always_comb begin
    m_enc     = (bus.funct7 == 7'b0000001);
    is_mdu_c  = bus.is_rtype & m_enc & ENABLE_M;
    illegal_c = bus.is_rtype & ~((bus.funct7 == 7'b0000000) |
                                 (bus.funct7 == 7'b0100000) |
                                 (m_enc & ENABLE_M));
    reg_write_c = ~illegal_c & (bus.is_rtype | bus.is_itype | bus.is_load | bus.is_jal |
                                bus.is_jalr | bus.is_lui | bus.is_auipc);
    mem_to_reg_c = 2'b00;
    if (bus.is_load)                   mem_to_reg_c = 2'b01;
    else if (bus.is_jal | bus.is_jalr) mem_to_reg_c = 2'b10;
    opa_sel_c = bus.is_branch | bus.is_jal | bus.is_auipc;
    opb_sel_c = bus.is_itype | bus.is_load | bus.is_store | bus.is_branch | bus.is_jal |
                bus.is_jalr | bus.is_lui | bus.is_auipc;
    alu_op_c = 5'b00000;
    if (bus.is_rtype)
      alu_op_c = is_mdu_c ? {2'b10, bus.funct3} : {1'b0, bus.funct7[5], bus.funct3};
    else if (bus.is_itype)
      alu_op_c = {1'b0, (bus.funct3 == 3'b101) & bus.funct7[5], bus.funct3};
    else if (bus.is_branch)
      alu_op_c = 5'b00001;
    else if (bus.is_lui)
      alu_op_c = 5'b01111;
  end

  // Hazard detection and combinational acceptance
  always_comb begin
    use_rs1   = bus.is_rtype | bus.is_itype | bus.is_load | bus.is_store | bus.is_branch |
                bus.is_jalr;
    use_rs2   = bus.is_rtype | bus.is_store | bus.is_branch;
    load_use  = valid_q & is_load_q & (rd_q != '0) &
                ((use_rs1 & (bus.rs1 == rd_q)) | (use_rs2 & (bus.rs2 == rd_q)));
    div_op    = is_mdu_c & bus.funct3[2];
    div_block = (div_cnt != '0) & div_op;
    hold      = valid_q & ~bus.ex_ready;
    id_ready_c = ~hold & ~load_use & ~div_block & ~bus.flush;
    accept    = bus.id_valid & id_ready_c;
  end

  // EX slot and divider occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      is_branch_q  <= 1'b0;
      is_jal_q     <= 1'b0;
      is_jalr_q    <= 1'b0;
      opa_sel_q    <= 1'b0;
      opb_sel_q    <= 1'b0;
      is_mdu_q     <= 1'b0;
      illegal_q    <= 1'b0;
      mem_to_reg_q <= 2'b00;
      alu_op_q     <= 5'b00000;
      rd_q         <= '0;
      div_cnt      <= '0;
    end else if (bus.flush) begin
      // Redirect squashes both the EX slot and any in-flight divide.
      valid_q <= 1'b0;
      div_cnt <= '0;
    end else begin
      if (!hold) valid_q <= accept;
      if (accept) begin
        reg_write_q  <= reg_write_c;
        is_load_q    <= bus.is_load & ~illegal_c;
        is_store_q   <= bus.is_store & ~illegal_c;
        is_branch_q  <= bus.is_branch & ~illegal_c;
        is_jal_q     <= bus.is_jal & ~illegal_c;
        is_jalr_q    <= bus.is_jalr & ~illegal_c;
        opa_sel_q    <= opa_sel_c;
        opb_sel_q    <= opb_sel_c;
        is_mdu_q     <= is_mdu_c;
        illegal_q    <= illegal_c;
        mem_to_reg_q <= mem_to_reg_c;
        alu_op_q     <= alu_op_c;
        rd_q         <= bus.rd;
      end
      if (accept && div_op)  div_cnt <= CNT_W'(DIV_LATENCY - 1);
      else if (div_cnt != '0) div_cnt <= div_cnt - CNT_W'(1);
    end
  end

  assign bus.id_ready      = id_ready_c;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_is_load    = is_load_q;
  assign bus.ex_is_store   = is_store_q;
  assign bus.ex_is_branch  = is_branch_q;
  assign bus.ex_is_jal     = is_jal_q;
  assign bus.ex_is_jalr    = is_jalr_q;
  assign bus.ex_opa_sel    = opa_sel_q;
  assign bus.ex_opb_sel    = opb_sel_q;
  assign bus.ex_is_mdu     = is_mdu_q;
  assign bus.ex_illegal    = illegal_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.ex_alu_op     = alu_op_q;
  assign bus.ex_rd         = rd_q;
  assign bus.mdu_busy      = (div_cnt != '0);
endmodule
